cc_flag_unit: RTL
=================

Name: cc_flag_unit

Overview:
Parametrised condition-code unit for the TB4004 core. It holds the carry, zero and synchronised TEST flags and applies flag-update commands from the decoder in a programmable machine cycle. It evaluates the JCN condition into a registered jump-qualify bit and adds a flag save/restore stack of configurable depth (for example, pushed on JMS and popped on BBL). It sits between the decoder/ALU and the program-counter/stack logic.

Parameters:
CYC_W, 3, width of the cycle input (A1..X3 = 0..7)
UPDATE_CYCLE, 7, cycle value in which ccOp is applied (X3)
EVAL_CYCLE, 6, cycle value in which the JCN condition is sampled (X2)
SYNC_STAGES, 2, flip-flop stages on testIn (minimum 1)
DEPTH, 3, flag-stack entries (minimum 1)
WRAP, 1, 1 = push when full overwrites the oldest entry; 0 = push when full is rejected
LVL_W, 2, width of stackLevel (must satisfy 2^LVL_W > DEPTH)

Ports:
clk  in  1  clock
rstN  in  1  asynchronous active-low reset
cycle  in  CYC_W  current machine cycle
testIn  in  1  external TEST pin, asynchronous
ccOp  in  3  flag command: 0 hold, 1 load C and Z, 2 load Z only, 3 clear C, 4 set C, 5 complement C, 6 CLB (C=0, Z=1), 7 hold
carryIn  in  1  ALU carry result
zeroIn  in  1  ALU zero result
cond  in  4  JCN condition nibble (OPA)
push  in  1  one-cycle pulse: save {C,Z}
pop  in  1  one-cycle pulse: restore {C,Z}
errClr  in  1  clears stackErr
carryFlag  out  1  carry flag
zeroFlag  out  1  zero flag
testFlag  out  1  synchronised TEST level
condTrue  out  1  registered JCN result
stackLevel  out  LVL_W  number of valid stack entries
stackEmpty  out  1  stackLevel == 0
stackFull  out  1  stackLevel == DEPTH
stackErr  out  1  sticky overflow/underflow error

Behaviour:
- Reset is asynchronous (rstN low). carryFlag, zeroFlag, testFlag, condTrue, stackErr and stackFull are all 0; stackEmpty is 1; stackLevel is 0; all sync stages are 0. Stack contents are not reset. Reset asserted mid-operation discards every pending effect.
- TEST sync: testFlag is testIn delayed by exactly SYNC_STAGES clocks.
- Flag update: ccOp acts only on the clock edge where cycle == UPDATE_CYCLE. In any other cycle ccOp is ignored. Codes 0 and 7 hold. Code 2 leaves C unchanged. Codes 3, 4 and 5 leave Z unchanged.
- Condition: c = (~testFlag & cond[0]) | (carryFlag & cond[1]) | (zeroFlag & cond[2]).
  - On the edge where cycle == EVAL_CYCLE, condTrue <= c ^ cond[3].
  - condTrue is held until the next EVAL_CYCLE edge.
  - Evaluation uses the register values before that edge.
- Stack, push only: writes the current {carryFlag, zeroFlag} (pre-edge values) and increments stackLevel.
  - If full and WRAP=1: the oldest entry is overwritten and stackLevel stays at DEPTH; no error.
  - If full and WRAP=0: the push is dropped and stackErr is set.
- Stack, pop only: loads carryFlag and zeroFlag from the newest entry and decrements stackLevel.
  - If empty: the flags are unchanged and stackErr is set.
- Priority:
  - Pop overrides ccOp in the same edge.
  - A push in the same edge as a ccOp update saves the pre-update flags and the ccOp update still applies.
  - push and pop in the same edge: stack and flags are unchanged, ccOp still applies, and stackErr is set.
- Error register: stackErr stays set until errClr. If errClr and a new error occur in the same edge, the error wins and stackErr stays 1.
- Status outputs: stackEmpty and stackFull are registered-consistent with stackLevel, decoded combinationally from it.
- Implementation: circular buffer with a write pointer; read index = write pointer − 1 modulo DEPTH, so the pointer wraps.

Test Plan:
- Reset, then cycle through 0..7 with ccOp=1, carryIn=1, zeroIn=1 → C=1 and Z=1 only after the cycle==7 edge; ccOp=1 applied at cycle 3 → no change.
- testIn 1→0 → testFlag falls exactly 2 clocks later; with cond=4'b0001 at cycle 6 → condTrue=1; with cond=4'b1001 → condTrue=0.
- C=1, Z=0, push; ccOp=6 at cycle 7 (C=0, Z=1); pop → C=1, Z=0, stackLevel back to 0, stackErr=0.
- DEPTH=3, WRAP=1: push {1,0}, {0,1}, {1,1}, {0,0} → stackLevel=3, stackFull=1; three pops return {0,0}, {1,1}, {0,1}; a fourth pop → stackErr=1 and flags unchanged.
- WRAP=0: four pushes → the fourth is dropped, stackErr=1, pops return the first three entries; errClr → stackErr=0.
- push and pop together with ccOp=4 at cycle 7 → stackLevel unchanged, C=1, stackErr=1; rstN low mid-sequence → all outputs at reset values immediately.

Source files
------------

// File: rtl/cc_flag_unit.sv
// cc_flag_unit: carry/zero/TEST condition codes, JCN qualify bit and a flag save stack.
// Ports: clk, rstN, cycle, testIn, ccOp, carryIn, zeroIn, cond, push, pop, errClr ->
//   carryFlag, zeroFlag, testFlag, condTrue, stackLevel, stackEmpty, stackFull, stackErr.
module cc_flag_unit #(
  parameter int CYC_W        = 3,
  parameter int UPDATE_CYCLE = 7,
  parameter int EVAL_CYCLE   = 6,
  parameter int SYNC_STAGES  = 2,
  parameter int DEPTH        = 3,
  parameter int WRAP         = 1,
  parameter int LVL_W        = 2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [CYC_W-1:0] cycle,
  input  logic             testIn,
  input  logic [2:0]       ccOp,
  input  logic             carryIn,
  input  logic             zeroIn,
  input  logic [3:0]       cond,
  input  logic             push,
  input  logic             pop,
  input  logic             errClr,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             testFlag,
  output logic             condTrue,
  output logic [LVL_W-1:0] stackLevel,
  output logic             stackEmpty,
  output logic             stackFull,
  output logic             stackErr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CYC_W-1:0] UPD  = CYC_W'(UPDATE_CYCLE);
  localparam logic [CYC_W-1:0] EVL  = CYC_W'(EVAL_CYCLE);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic             WRP  = (WRAP != 0);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [1:0]             mem [DEPTH];
  logic [PTR_W-1:0]       wrPtr;
  logic [PTR_W-1:0]       rdPtr;
  logic [PTR_W-1:0]       wrNext;
  logic [LVL_W-1:0]       level;

  logic full;
  logic empty;
  logic popOnly;
  logic pushOnly;
  logic doPush;
  logic doPop;
  logic errSet;
  logic cEval;
  logic cNext;
  logic zNext;

  assign empty    = (level == '0);
  assign full     = (level == FULL);
  assign popOnly  = pop & ~push;
  assign pushOnly = push & ~pop;
  assign doPush   = pushOnly & (~full | WRP);
  assign doPop    = popOnly & ~empty;
  assign errSet   = (push & pop)
                  | (popOnly & empty)
                  | (pushOnly & full & ~WRP);

  // Newest entry sits just behind the write pointer.
  assign rdPtr  = (wrPtr == '0) ? LAST : wrPtr - PTR_W'(1);
  assign wrNext = (wrPtr == LAST) ? '0 : wrPtr + PTR_W'(1);

  assign cEval = (~testFlag & cond[0])
               | (carryFlag & cond[1])
               | (zeroFlag & cond[2]);

  // A pop (even a failed one on an empty stack) masks ccOp.
  always_comb begin
    cNext = carryFlag;
    zNext = zeroFlag;
    if (doPop) begin
      {cNext, zNext} = mem[rdPtr];
    end else if (!popOnly && cycle == UPD) begin
      case (ccOp)
        3'd1: begin
          cNext = carryIn;
          zNext = zeroIn;
        end
        3'd2: zNext = zeroIn;
        3'd3: cNext = 1'b0;
        3'd4: cNext = 1'b1;
        3'd5: cNext = ~carryFlag;
        3'd6: begin
          cNext = 1'b0;
          zNext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncQ     <= '0;
      carryFlag <= 1'b0;
      zeroFlag  <= 1'b0;
      condTrue  <= 1'b0;
      level     <= '0;
      wrPtr     <= '0;
      stackErr  <= 1'b0;
    end else begin
      syncQ     <= (syncQ << 1) | SYNC_STAGES'(testIn);
      carryFlag <= cNext;
      zeroFlag  <= zNext;
      if (cycle == EVL) begin
        condTrue <= cEval ^ cond[3];
      end
      if (doPush) begin
        wrPtr <= wrNext;
        if (!full) begin
          level <= level + LVL_W'(1);
        end
      end else if (doPop) begin
        wrPtr <= rdPtr;
        level <= level - LVL_W'(1);
      end
      if (errSet) begin
        stackErr <= 1'b1;
      end else if (errClr) begin
        stackErr <= 1'b0;
      end
    end
  end

  // Stack storage carries no reset; the level counter alone defines validity.
  always_ff @(posedge clk) begin
    if (doPush && rstN) begin
      mem[wrPtr] <= {carryFlag, zeroFlag};
    end
  end

  assign testFlag   = syncQ[SYNC_STAGES-1];
  assign stackLevel = level;
  assign stackEmpty = empty;
  assign stackFull  = full;

endmodule
